// File: rtl/screen_pkg.sv
// -----------------------------------------------------------------------------
// screen_pkg
// Shared definitions for the OLED game-UI screen sequencer:
//   - screen identifiers (also the index of each renderer slice on scr_data)
//   - button bit positions inside the packed {C,R,L,U,D} button vector
//   - RGB565 colour constants
//   - bounds of the blinking ">>>" arrow on the control screens
//   - transition table helpers: which buttons do something on a given
//     screen, and which screen a button leads to
// -----------------------------------------------------------------------------
package screen_pkg;

  typedef enum logic [2:0] {
    SCR_TITLE = 3'd0,
    SCR_CTRL1 = 3'd1,
    SCR_CTRL2 = 3'd2,
    SCR_PLAY  = 3'd3,
    SCR_PAUSE = 3'd4,
    SCR_OVER  = 3'd5
  } screen_e;

  // Bit positions in the button vector; higher bit = higher priority.
  localparam int unsigned NUM_BTNS = 5;
  localparam int unsigned BTN_C    = 4;
  localparam int unsigned BTN_R    = 3;
  localparam int unsigned BTN_L    = 2;
  localparam int unsigned BTN_U    = 1;
  localparam int unsigned BTN_D    = 0;

  // RGB565 colours
  localparam logic [15:0] COL_BLACK = 16'h0000;
  localparam logic [15:0] COL_WHITE = 16'hFFFF;

  // Arrow box on the control screens (inclusive bounds)
  localparam logic [6:0] ARROW_X_LO = 7'd86;
  localparam logic [6:0] ARROW_X_HI = 7'd93;
  localparam logic [5:0] ARROW_Y_LO = 6'd57;
  localparam logic [5:0] ARROW_Y_HI = 6'd59;

  // Buttons that have a transition defined from screen s.
  function automatic logic [NUM_BTNS-1:0] btn_mask(input screen_e s);
    logic [NUM_BTNS-1:0] m;
    m = 5'b00000;
    case (s)
      SCR_TITLE: m[BTN_C] = 1'b1;
      SCR_CTRL1: begin m[BTN_R] = 1'b1; m[BTN_L] = 1'b1; end
      SCR_CTRL2: begin m[BTN_C] = 1'b1; m[BTN_L] = 1'b1; end
      SCR_PLAY:  m[BTN_C] = 1'b1;
      SCR_PAUSE: begin m[BTN_C] = 1'b1; m[BTN_L] = 1'b1; end
      SCR_OVER:  m[BTN_C] = 1'b1;
      default:   m = 5'b00000;
    endcase
    return m;
  endfunction

  // Destination screen for an accepted one-hot button b on screen s.
  function automatic screen_e btn_target(input screen_e s, input logic [NUM_BTNS-1:0] b);
    screen_e t;
    case (s)
      SCR_TITLE: t = SCR_CTRL1;
      SCR_CTRL1: t = b[BTN_R] ? SCR_CTRL2 : SCR_TITLE;
      SCR_CTRL2: t = b[BTN_C] ? SCR_PLAY : SCR_CTRL1;
      SCR_PLAY:  t = SCR_PAUSE;
      SCR_PAUSE: t = b[BTN_C] ? SCR_PLAY : SCR_TITLE;
      SCR_OVER:  t = SCR_TITLE;
      default:   t = SCR_TITLE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/screen_sequencer_btn_arbiter.sv
// -----------------------------------------------------------------------------
// btn_arbiter
// Rising-edge detection on the five buttons, priority selection of a single
// winner (C > R > L > U > D) and the post-press holdoff window.
// The winner is chosen among all rising edges first; if it has no transition
// on the current screen the press is dropped and the holdoff is not started.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   btn_i        packed {C,R,L,U,D} levels
//   valid_i      buttons that have a transition from the displayed screen
//   block_i      suppress acceptance (request pending or game-over override)
//   accept_o     one-hot accepted button, single-cycle, combinational
// -----------------------------------------------------------------------------
module btn_arbiter
  import screen_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYC = 1250000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btn_i,
  input  logic [NUM_BTNS-1:0] valid_i,
  input  logic                block_i,
  output logic [NUM_BTNS-1:0] accept_o
);

  localparam int unsigned HOLD_W = $clog2(HOLDOFF_CYC + 1);

  logic [NUM_BTNS-1:0] prev_q;
  logic [HOLD_W-1:0]   holdoff_q;
  logic [NUM_BTNS-1:0] edge_s;
  logic [NUM_BTNS-1:0] win_s;

  assign edge_s = btn_i & ~prev_q;

  // Pick the single highest-priority rising edge.
  always_comb begin
    win_s = 5'b00000;
    if (edge_s[BTN_C])      win_s[BTN_C] = 1'b1;
    else if (edge_s[BTN_R]) win_s[BTN_R] = 1'b1;
    else if (edge_s[BTN_L]) win_s[BTN_L] = 1'b1;
    else if (edge_s[BTN_U]) win_s[BTN_U] = 1'b1;
    else if (edge_s[BTN_D]) win_s[BTN_D] = 1'b1;
    else                    win_s = 5'b00000;
  end

  // Accept the winner only if it is meaningful here and nothing blocks it.
  always_comb begin
    accept_o = 5'b00000;
    if ((holdoff_q == '0) && !block_i) accept_o = win_s & valid_i;
    else                               accept_o = 5'b00000;
  end

  // Edge history and holdoff counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= 5'b00000;
      holdoff_q <= '0;
    end else begin
      prev_q <= btn_i;
      if (|accept_o)             holdoff_q <= HOLD_W'(HOLDOFF_CYC);
      else if (holdoff_q != '0)  holdoff_q <= holdoff_q - HOLD_W'(1);
    end
  end

endmodule

// File: rtl/screen_sequencer.sv
// -----------------------------------------------------------------------------
// screen_sequencer
// Screen controller for the 96x64 OLED game UI. Button presses and the
// game-over level request a new screen; the request is committed only on a
// frame boundary so a frame is never drawn from two renderers. The active
// renderer's pixel is registered onto oled_data, with the ">>>" arrow on the
// control screens blanked during the off half of the blink.
// Ports:
//   clk, rst_n                    pixel clock, asynchronous active-low reset
//   btn_c/u/d/l/r                 debounced, synchronised button levels
//   game_over                     level from game logic
//   frame_begin                   one-cycle pulse at pixel 0 of a frame
//   x, y                          current pixel column / row
//   scr_data                      RGB565 per renderer, slice i = screen i
//   oled_data                     registered pixel
//   screen_id                     displayed screen
//   play_en                       displayed screen is PLAY
//   game_rst                      pulse on CTRL2 -> PLAY commit
// -----------------------------------------------------------------------------
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int unsigned NUM_SCREENS  = 6,
  parameter int unsigned HOLDOFF_CYC  = 1250000,
  parameter int unsigned BLINK_FRAMES = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      btn_c,
  input  logic                      btn_u,
  input  logic                      btn_d,
  input  logic                      btn_l,
  input  logic                      btn_r,
  input  logic                      game_over,
  input  logic                      frame_begin,
  input  logic [6:0]                x,
  input  logic [5:0]                y,
  input  logic [16*NUM_SCREENS-1:0] scr_data,
  output logic [15:0]               oled_data,
  output logic [2:0]                screen_id,
  output logic                      play_en,
  output logic                      game_rst
);

  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  screen_e             disp_q;
  screen_e             pend_q;
  logic                pend_vld_q;
  logic                play_en_q;
  logic                game_rst_q;
  logic                blink_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [15:0]         oled_q;

  logic [NUM_BTNS-1:0] btn_s;
  logic [NUM_BTNS-1:0] mask_s;
  logic [NUM_BTNS-1:0] accept_s;
  logic                go_s;
  logic                commit_s;
  logic                req_vld_d;
  screen_e             req_scr_d;
  logic                blank_s;
  logic [15:0]         pix_d;

  assign btn_s    = {btn_c, btn_r, btn_l, btn_u, btn_d};
  assign mask_s   = btn_mask(disp_q);
  assign go_s     = game_over && (disp_q == SCR_PLAY);
  assign commit_s = frame_begin && pend_vld_q;

  btn_arbiter #(
    .HOLDOFF_CYC (HOLDOFF_CYC)
  ) u_btn_arbiter (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_i    (btn_s),
    .valid_i  (mask_s),
    .block_i  (pend_vld_q | go_s),
    .accept_o (accept_s)
  );

  // New request this cycle; game over beats any button.
  always_comb begin
    req_vld_d = 1'b0;
    req_scr_d = pend_q;
    if (go_s) begin
      req_vld_d = 1'b1;
      req_scr_d = SCR_OVER;
    end else if (|accept_s) begin
      req_vld_d = 1'b1;
      req_scr_d = btn_target(disp_q, accept_s);
    end else begin
      req_vld_d = 1'b0;
      req_scr_d = pend_q;
    end
  end

  // Arrow blanking and renderer select for the next pixel.
  always_comb begin
    blank_s = 1'b0;
    pix_d   = COL_BLACK;
    if (((disp_q == SCR_CTRL1) || (disp_q == SCR_CTRL2)) && !blink_q &&
        (x >= ARROW_X_LO) && (x <= ARROW_X_HI) &&
        (y >= ARROW_Y_LO) && (y <= ARROW_Y_HI)) begin
      blank_s = 1'b1;
    end else begin
      blank_s = 1'b0;
    end
    if (blank_s || (32'(disp_q) >= NUM_SCREENS)) pix_d = COL_BLACK;
    else                                         pix_d = scr_data[16*32'(disp_q) +: 16];
  end

  // Screen state machine: commit on frame boundary, pending request, blink.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q     <= SCR_TITLE;
      pend_q     <= SCR_TITLE;
      pend_vld_q <= 1'b0;
      play_en_q  <= 1'b0;
      game_rst_q <= 1'b0;
      blink_q    <= 1'b1;
      cnt_q      <= '0;
    end else begin
      game_rst_q <= 1'b0;
      if (commit_s) begin
        disp_q     <= pend_q;
        play_en_q  <= (pend_q == SCR_PLAY);
        game_rst_q <= (disp_q == SCR_CTRL2) && (pend_q == SCR_PLAY);
        pend_vld_q <= 1'b0;
      end
      // A request in the commit cycle survives to the next frame.
      if (req_vld_d) begin
        pend_q     <= req_scr_d;
        pend_vld_q <= 1'b1;
      end
      if (commit_s && (pend_q != disp_q)) begin
        cnt_q   <= '0;
        blink_q <= 1'b1;
      end else if (frame_begin) begin
        if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
          cnt_q   <= '0;
          blink_q <= ~blink_q;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Registered pixel output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) oled_q <= COL_BLACK;
    else        oled_q <= pix_d;
  end

  assign oled_data = oled_q;
  assign screen_id = disp_q;
  assign play_en   = play_en_q;
  assign game_rst  = game_rst_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// -----------------------------------------------------------------------------
// tb_screen_sequencer
// Directed bench for screen_sequencer with a short holdoff (8 cycles) and a
// two-frame blink half-period. Inputs change and outputs are checked on the
// falling clock edge; the DUT samples on the rising edge.
// -----------------------------------------------------------------------------
module tb_screen_sequencer;

  localparam int unsigned NS = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4:0]      btns;        // {C,R,L,U,D}
  logic            game_over;
  logic            frame_begin;
  logic [6:0]      x_v;
  logic [5:0]      y_v;
  logic [16*NS-1:0] scr_v;
  logic [15:0]     oled_data;
  logic [2:0]      screen_id;
  logic            play_en;
  logic            game_rst;

  int nvec = 0;
  int nerr = 0;

  localparam logic [4:0] B_C = 5'b10000;
  localparam logic [4:0] B_R = 5'b01000;
  localparam logic [4:0] B_L = 5'b00100;

  screen_sequencer #(
    .NUM_SCREENS  (NS),
    .HOLDOFF_CYC  (8),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_c       (btns[4]),
    .btn_u       (btns[1]),
    .btn_d       (btns[0]),
    .btn_l       (btns[2]),
    .btn_r       (btns[3]),
    .game_over   (game_over),
    .frame_begin (frame_begin),
    .x           (x_v),
    .y           (y_v),
    .scr_data    (scr_v),
    .oled_data   (oled_data),
    .screen_id   (screen_id),
    .play_en     (play_en),
    .game_rst    (game_rst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [4:0] b);
    btns = b;
    step();
    btns = 5'b00000;
    step();
  endtask

  task automatic frame();
    frame_begin = 1'b1;
    step();
    frame_begin = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    btns        = 5'b00000;
    game_over   = 1'b0;
    frame_begin = 1'b0;
    x_v         = 7'd0;
    y_v         = 6'd0;
    scr_v       = {16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'hFFFF, 16'h1000};

    // Reset state
    wait_cyc(2);
    chk("rst_screen",  16'(screen_id), 16'd0);
    chk("rst_oled",    oled_data,      16'h0000);
    chk("rst_play_en", 16'(play_en),   16'd0);
    chk("rst_game_rst",16'(game_rst),  16'd0);
    rst_n = 1'b1;
    step();
    chk("title_pixel", oled_data, 16'h1000);

    // TITLE -> CTRL1 only at frame_begin; repeat press while pending ignored
    press(B_C);
    chk("pend_no_commit", 16'(screen_id), 16'd0);
    step();
    press(B_C);
    chk("second_c_pend", 16'(screen_id), 16'd0);
    frame();
    chk("commit_ctrl1", 16'(screen_id), 16'd1);

    // R inside holdoff is lost
    press(B_R);
    wait_cyc(3);
    frame();
    chk("holdoff_reject", 16'(screen_id), 16'd1);
    press(B_R);
    chk("r_pending", 16'(screen_id), 16'd1);
    frame();
    chk("commit_ctrl2", 16'(screen_id), 16'd2);

    // CTRL2 -> PLAY with one-cycle game_rst
    wait_cyc(10);
    press(B_C);
    frame();
    chk("play_screen",   16'(screen_id), 16'd3);
    chk("play_en_on",    16'(play_en),   16'd1);
    chk("game_rst_high", 16'(game_rst),  16'd1);
    step();
    chk("game_rst_low",  16'(game_rst),  16'd0);
    chk("play_pixel",    oled_data,      16'h3333);

    // PLAY -> PAUSE -> PLAY, no game_rst
    wait_cyc(10);
    press(B_C);
    frame();
    chk("pause_screen",  16'(screen_id), 16'd4);
    chk("pause_play_en", 16'(play_en),   16'd0);
    chk("pause_no_rst",  16'(game_rst),  16'd0);
    wait_cyc(10);
    press(B_C);
    frame();
    chk("resume_screen", 16'(screen_id), 16'd3);
    chk("resume_no_rst", 16'(game_rst),  16'd0);

    // game_over beats C in the same cycle
    wait_cyc(10);
    btns      = B_C;
    game_over = 1'b1;
    step();
    btns      = 5'b00000;
    game_over = 1'b0;
    step();
    chk("over_pending", 16'(screen_id), 16'd3);
    frame();
    chk("over_screen",  16'(screen_id), 16'd5);
    step();
    chk("over_stays",   16'(screen_id), 16'd5);

    // OVER -> TITLE -> CTRL1
    wait_cyc(10);
    press(B_C);
    frame();
    chk("over_to_title", 16'(screen_id), 16'd0);
    wait_cyc(10);
    press(B_C);
    frame();
    chk("title_to_ctrl1", 16'(screen_id), 16'd1);

    // C and R together on CTRL1: C wins, has no transition, nothing happens
    wait_cyc(10);
    btns = B_C | B_R;
    step();
    btns = 5'b00000;
    step();
    frame();
    chk("cr_discard", 16'(screen_id), 16'd1);
    press(B_R);
    frame();
    chk("r_after_discard", 16'(screen_id), 16'd2);

    // Back to CTRL1 at the arrow, then blink
    x_v = 7'd88;
    y_v = 6'd58;
    wait_cyc(10);
    press(B_L);
    frame();
    chk("ctrl1_again", 16'(screen_id), 16'd1);
    step();
    chk("blink_f0", oled_data, 16'hFFFF);
    frame(); step();
    chk("blink_f1", oled_data, 16'hFFFF);
    frame(); step();
    chk("blink_f2", oled_data, 16'h0000);
    x_v = 7'd86; y_v = 6'd57; step();
    chk("arrow_lo_corner", oled_data, 16'h0000);
    x_v = 7'd93; y_v = 6'd59; step();
    chk("arrow_hi_corner", oled_data, 16'h0000);
    x_v = 7'd94; step();
    chk("arrow_x_out", oled_data, 16'hFFFF);
    x_v = 7'd93; y_v = 6'd60; step();
    chk("arrow_y_out", oled_data, 16'hFFFF);
    x_v = 7'd80; y_v = 6'd58; step();
    chk("x80_off_phase", oled_data, 16'hFFFF);
    x_v = 7'd88;
    frame(); step();
    chk("blink_f3", oled_data, 16'h0000);
    frame(); step();
    chk("blink_f4", oled_data, 16'hFFFF);

    // One-cycle pixel latency
    x_v = 7'd80;
    step();
    scr_v[31:16] = 16'h1234;
    #1;
    chk("latency_old", oled_data, 16'hFFFF);
    step();
    chk("latency_new", oled_data, 16'h1234);
    scr_v[31:16] = 16'hFFFF;

    // Async reset with a request pending
    wait_cyc(10);
    press(B_R);
    chk("pre_rst_screen", 16'(screen_id), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("async_screen",  16'(screen_id), 16'd0);
    chk("async_oled",    oled_data,      16'h0000);
    chk("async_play_en", 16'(play_en),   16'd0);
    chk("async_game_rst",16'(game_rst),  16'd0);
    step();
    rst_n = 1'b1;
    step();
    frame();
    step();
    chk("no_stale_commit", 16'(screen_id), 16'd0);
    chk("title_after_rst", oled_data,      16'h1000);

    // Button held through reset release counts as one press
    btns  = B_C;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    btns = 5'b00000;
    step();
    frame();
    chk("held_through_rst", 16'(screen_id), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
